// File: rtl/stopwatch_pkg.sv
// Shared encodings and widths for the stopwatch controller: FSM states,
// BCD digit sizing and per-digit wrap limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int DIGIT_W         = 4;
  localparam int TIME_W          = 6 * DIGIT_W;
  localparam int DIGIT_MAX_UNITS = 9;
  localparam int DIGIT_MAX_TENS  = 5;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the time chain: counts 0..MAX_VAL when enabled and
// raises carry in the cycle it wraps, so digits cascade enable-to-carry.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int MAX_VAL = DIGIT_MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic       carry,
  output bcd_digit_t digit
);

  localparam bcd_digit_t MAX_D = DIGIT_W'(MAX_VAL);

  bcd_digit_t digit_q, digit_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en) begin
      digit_d = (digit_q == MAX_D) ? '0 : digit_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign carry = en && (digit_q == MAX_D);
  assign digit = digit_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause FSM, base-tick prescaler and a six-digit
// BCD mm:ss.hh chain. Define STOPWATCH_LAP_EN to build the lap-capture register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic              running,
  output logic              tick_100hz,
  output logic              tick_1hz,
  output logic [TIME_W-1:0] time_bcd,
  output logic              rollover,
  output logic [TIME_W-1:0] lap_bcd,
  output logic              lap_valid
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end

  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_stop) state_d = ST_RUN;
      ST_RUN:   if (start_stop) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (start_stop) state_d = ST_RUN;
        else if (clear) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // clear wins over an in-flight tick so the zeroed time is not bumped to .01
  assign running    = (state_q == ST_RUN);
  assign tick_100hz = running && (presc_q == PW'(DIV - 1)) && !clear;

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (running) begin
      presc_d = tick_100hz ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  bcd_digit_t hund_o, hund_t, sec_o, sec_t, min_o, min_t;
  logic       c_hund_o, c_hund_t, c_sec_o, c_sec_t, c_min_o, c_min_t;

  bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX_UNITS)) u_hund_o (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(tick_100hz), .carry(c_hund_o), .digit(hund_o)
  );
  bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX_UNITS)) u_hund_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(c_hund_o), .carry(c_hund_t), .digit(hund_t)
  );
  bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX_UNITS)) u_sec_o (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(c_hund_t), .carry(c_sec_o), .digit(sec_o)
  );
  bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX_TENS)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(c_sec_o), .carry(c_sec_t), .digit(sec_t)
  );
  bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX_UNITS)) u_min_o (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(c_sec_t), .carry(c_min_o), .digit(min_o)
  );
  bcd_digit_cnt #(.MAX_VAL(DIGIT_MAX_TENS)) u_min_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(c_min_o), .carry(c_min_t), .digit(min_t)
  );

  assign time_bcd = {min_t, min_o, sec_t, sec_o, hund_t, hund_o};
  assign tick_1hz = c_hund_t;
  assign rollover = c_min_t;

`ifdef STOPWATCH_LAP_EN
  logic [TIME_W-1:0] lap_bcd_q, lap_bcd_d;
  logic              lap_valid_q, lap_valid_d;

  // time_bcd is still the pre-increment value during a tick cycle
  always_comb begin
    lap_bcd_d   = lap_bcd_q;
    lap_valid_d = lap_valid_q;
    if (clear) begin
      lap_bcd_d   = '0;
      lap_valid_d = 1'b0;
    end else if (lap && running) begin
      lap_bcd_d   = time_bcd;
      lap_valid_d = 1'b1;
    end
  end

  // NOTE: the lap register is a single word of control-visible state, so it is reset like any flop rather than left uninitialised as a memory array would be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_bcd_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_bcd_q   <= lap_bcd_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_bcd   = lap_bcd_q;
  assign lap_valid = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_bcd    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, base tick rate; DIV = CLK_HZ/TICK_HZ, integer, >= 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_stop  input  1  single-cycle command pulse: toggle run/pause.
REQ-006 clear  input  1  single-cycle command pulse: zero time and prescaler.
REQ-007 lap  input  1  single-cycle command pulse: capture current time.
REQ-008 running  output  1  high while state is RUN.
REQ-009 tick_100hz  output  1  one-cycle strobe per base tick; not a clock.
REQ-010 tick_1hz  output  1  one-cycle strobe when seconds increment.
REQ-011 time_bcd  output  24  {min_t,min_o,sec_t,sec_o,hund_t,hund_o}, 4 bits each.
REQ-012 rollover  output  1  one-cycle strobe on wrap 59:59.99 -> 00:00.00.
REQ-013 lap_bcd  output  24  captured time, same packing (STOPWATCH_LAP_EN only).
REQ-014 lap_valid  output  1  high after first capture until clear (STOPWATCH_LAP_EN only).

Function
REQ-015 States IDLE, RUN, PAUSE; IDLE-start_stop->RUN; RUN-start_stop->PAUSE; PAUSE-start_stop->RUN; PAUSE-clear->IDLE; RUN-clear stays RUN; IDLE-clear stays IDLE.
REQ-016 Prescaler counts 0..DIV-1 only in RUN; tick_100hz asserted in the cycle prescaler==DIV-1 and state is RUN; prescaler then wraps to 0.
REQ-017 time_bcd increments on the edge ending a tick_100hz cycle; new value visible the following cycle.
REQ-018 Digit carries: hund 00..99, sec 00..59, min 00..59; every digit stays legal BCD (0-9, tens of sec/min 0-5).
REQ-019 tick_1hz asserted coincident with tick_100hz when hund==99; rollover coincident with tick_100hz when time is 59:59.99.
REQ-020 PAUSE holds prescaler and time unchanged; resume continues from held prescaler value (no lost fraction).
REQ-021 clear zeroes time_bcd and prescaler on the next edge in any state; clear in RUN suppresses any tick that cycle.
REQ-022 start_stop and clear in the same cycle: clear applied to counters, state transition per start_stop (IDLE/PAUSE->RUN, RUN->PAUSE).
REQ-023 lap accepted only in RUN; lap coincident with a tick captures the pre-increment value.
REQ-024 Commands held high longer than one cycle are acted on every cycle; upstream supplies pulses.

Reset
REQ-025 On rst_n low: state IDLE, prescaler 0, time_bcd 0, lap_bcd 0, lap_valid 0, running/tick_100hz/tick_1hz/rollover 0.
REQ-026 Reset mid-RUN aborts immediately; after release, first start_stop starts timing from 00:00.00 with a full DIV-cycle first tick.

Configuration
REQ-027 Macro STOPWATCH_LAP_EN defined: lap register, lap_bcd, lap_valid implemented; clear zeroes lap_bcd and lap_valid.
REQ-028 Macro STOPWATCH_LAP_EN undefined: lap input ignored, lap_bcd tied 0, lap_valid tied 0, no lap register.

Structure
REQ-029 Package stopwatch_pkg holds state encoding (IDLE=0, RUN=1, PAUSE=2), BCD digit width 4, packed-time width 24, digit limits 9/5.
REQ-030 Sub-module bcd_digit_cnt (enable in, carry out, max-value parameter) instantiated six times; prescaler and FSM in top.

Verification (CLK_HZ=1000, TICK_HZ=100, DIV=10)
REQ-031 Reset, start_stop pulse, run 100 clocks -> 10 tick_100hz strobes, time_bcd=00:00.10, tick_1hz never high.
REQ-032 Run 1000 clocks -> time_bcd=00:01.00, tick_1hz exactly once, coincident with tick 100.
REQ-033 start_stop at prescaler=4, wait 50 clocks, start_stop -> no ticks while paused; next tick 5 clocks after resume.
REQ-034 Force time 59:59.99, one tick -> time_bcd=00:00.00, rollover and tick_1hz single-cycle high.
REQ-035 Lap coincident with tick at 00:00.05 -> lap_bcd=00:00.05, lap_valid=1; clear -> lap_bcd=0, lap_valid=0 (LAP_EN build).
REQ-036 start_stop and clear same cycle in RUN at 00:00.30 -> state PAUSE, time_bcd=00:00.00, prescaler 0; rst_n low mid-RUN -> all outputs 0 asynchronously.
